pc_fetch_ctl: RTL and testbench
===============================

Name: pc_fetch_ctl

Overview:
Program-counter and fetch-control stage of the processor, directly downstream of the 12-bit branch-target LUT. Holds the PC and drives the LUT index from the instruction's branch field. Consumes the LUT's target as either an absolute address or a signed relative offset. Sequences the program with a start/done handshake to the testbench and counts run cycles.

Parameters:
D, 12, PC and branch-target width; all PC arithmetic is modulo 2**D.
AW, 4, width of the LUT index field.
CW, 16, width of the run-cycle counter.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a program run from PC 0
stall  input  1  hold the PC this cycle; the instruction at pc is not consumed
halt_req  input  1  the current instruction is a halt (decoded)
branch_en  input  1  the current instruction is a branch
branch_rel  input  1  1 = target is a relative offset; 0 = target is absolute
taken  input  1  branch condition flag from the ALU
br_idx  input  AW  branch index field of the current instruction
lut_addr  output  AW  index to the target LUT; combinational copy of br_idx
target  input  D  target returned by the LUT
pc  output  D  current program counter (instruction-memory address)
fetch_valid  output  1  the instruction at pc is consumed this cycle
running  output  1  FSM is in RUN
done  output  1  FSM is in HALT; program finished
cycle_cnt  output  CW  number of cycles spent in RUN this run

Behaviour:
- FSM states: IDLE, RUN, HALT. All state is registered on the rising edge of clk.
- Reset (synchronous, highest priority):
  - state=IDLE, pc=0, cycle_cnt=0.
  - Consequently running=0, done=0, fetch_valid=0.
  - Reset asserted mid-RUN aborts the run on that edge; no branch or increment is applied.
- IDLE:
  - pc holds 0.
  - start=1 -> RUN, pc=0, cycle_cnt=0.
  - All other inputs are ignored.
- RUN, first cycle: the instruction at address 0 is presented with fetch_valid=1 in the first RUN cycle, unless stall is high.
- RUN priority per cycle: stall > halt_req > taken branch > sequential.
  - stall=1: pc holds. halt_req, branch_en, taken and start are ignored.
  - halt_req=1 (no stall): pc holds; next state is HALT.
  - branch_en=1 and taken=1: pc <= (branch_rel ? pc + target : target), truncated to D bits. A relative target is a two's-complement offset, e.g. 0xFFF = -1.
  - Otherwise: pc <= pc + 1. 0xFFF + 1 wraps to 0x000 with no flag and no halt.
  - branch_en=1 with taken=0 behaves exactly like the sequential case.
  - start in RUN is ignored.
- Cycle counter:
  - cycle_cnt increments by 1 on every RUN cycle, stalled cycles included.
  - It saturates at 2**CW-1 and does not wrap.
  - It freezes in HALT and is cleared only by reset or a new start.
- HALT:
  - done=1 and pc holds the halt instruction's address; both stay stable indefinitely.
  - start=1 -> RUN with pc=0 and cycle_cnt=0. done drops on that same edge.
- Outputs:
  - running = (state==RUN).
  - done = (state==HALT).
  - fetch_valid = running & ~stall.
- Latency: lut_addr and fetch_valid are combinational. The effect of a branch, halt or increment is visible on pc one cycle later.
- The block adds no extra cycle between reading target and using it; the LUT is combinational.

Test Plan:
- Reset then start pulse -> pc sequence 0,1,2,3 over four cycles; fetch_valid=1 throughout; cycle_cnt=4 after four RUN cycles.
- pc=4, branch_en=1, taken=1, branch_rel=1, target=0xFFF -> next pc=3. pc=20 with target=0xFFB -> next pc=15.
- Absolute branch, branch_rel=0, target=0x123 from pc=7 -> pc=0x123. Same stimulus with taken=0 -> pc=8.
- Wrap-around: relative target 0x014 (+20) from pc=0xFF0 -> pc=0x004. Sequential increment from pc=0xFFF -> pc=0x000, state stays RUN.
- stall=1 for 3 cycles together with halt_req=1 and a taken branch -> pc unchanged, fetch_valid=0, cycle_cnt +3, still RUN. On releasing stall with halt_req=1 -> HALT, done=1, pc held. A later start -> pc=0, done=0, cycle_cnt cleared.
- Reset asserted mid-RUN while a taken branch is pending -> next edge shows pc=0, IDLE, done=0, cycle_cnt=0. The branch is not applied.

Source files
------------

// File: rtl/pc_fetch_ctl.sv
// Program-counter and fetch-control stage: IDLE/RUN/HALT sequencer that walks the PC,
// applies absolute or relative branch targets from the combinational LUT, and counts run cycles.
module pc_fetch_ctl #(
   parameter int D  = 12,
   parameter int AW = 4,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          stall,
   input  logic          halt_req,
   input  logic          branch_en,
   input  logic          branch_rel,
   input  logic          taken,
   input  logic [AW-1:0] br_idx,
   output logic [AW-1:0] lut_addr,
   input  logic [D-1:0]  target,
   output logic [D-1:0]  pc,
   output logic          fetch_valid,
   output logic          running,
   output logic          done,
   output logic [CW-1:0] cycle_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [D-1:0]  r_pc;
   logic [D-1:0]  w_pc_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [D-1:0]  w_br_pc;

   function automatic logic [CW-1:0] f_sat_inc(input logic [CW-1:0] v);
      if (&v) f_sat_inc = v;
      else    f_sat_inc = v + CW'(1);
   endfunction

   // Two's-complement offset add is the same bit pattern as a modulo-2**D unsigned add.
   assign w_br_pc = branch_rel ? (r_pc + target) : target;

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            w_pc_nxt = '0;
            if (start) begin
               w_state_nxt = S_RUN;
               w_cnt_nxt   = '0;
            end
         end
         S_RUN: begin
            w_cnt_nxt = f_sat_inc(r_cnt);
            if (stall) begin
               w_pc_nxt = r_pc;
            end else if (halt_req) begin
               w_state_nxt = S_HALT;
            end else if (branch_en && taken) begin
               w_pc_nxt = w_br_pc;
            end else begin
               w_pc_nxt = r_pc + D'(1);
            end
         end
         S_HALT: begin
            if (start) begin
               w_state_nxt = S_RUN;
               w_pc_nxt    = '0;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_pc_nxt    = '0;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_pc    <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   assign lut_addr    = br_idx;
   assign pc          = r_pc;
   assign cycle_cnt   = r_cnt;
   assign running     = (r_state == S_RUN);
   assign done        = (r_state == S_HALT);
   assign fetch_valid = running & ~stall;

endmodule

// File: tb/tb_pc_fetch_ctl.sv
// Bench for pc_fetch_ctl: directed scenarios plus randomized cycles against a behavioural model.
module tb_pc_fetch_ctl;
   localparam int D    = 12;
   localparam int AW   = 4;
   localparam int CW_T = 8;
   localparam int CMAX = (1 << CW_T) - 1;
   localparam int PMOD = 1 << D;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            start = 1'b0;
   logic            stall = 1'b0;
   logic            halt_req = 1'b0;
   logic            branch_en = 1'b0;
   logic            branch_rel = 1'b0;
   logic            taken = 1'b0;
   logic [AW-1:0]   br_idx = '0;
   logic [AW-1:0]   lut_addr;
   logic [D-1:0]    target = '0;
   logic [D-1:0]    pc;
   logic            fetch_valid;
   logic            running;
   logic            done;
   logic [CW_T-1:0] cycle_cnt;

   pc_fetch_ctl #(.D(D), .AW(AW), .CW(CW_T)) dut (
      .clk(clk), .reset(reset), .start(start), .stall(stall), .halt_req(halt_req),
      .branch_en(branch_en), .branch_rel(branch_rel), .taken(taken), .br_idx(br_idx),
      .lut_addr(lut_addr), .target(target), .pc(pc), .fetch_valid(fetch_valid),
      .running(running), .done(done), .cycle_cnt(cycle_cnt)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state: 0 = idle, 1 = run, 2 = halted
   int m_st  = 0;
   int m_pc  = 0;
   int m_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic cyc(input logic i_rst, input logic i_st, input logic i_stl, input logic i_hr,
                      input logic i_be, input logic i_rel, input logic i_tk,
                      input int i_idx, input int i_tg);
      reset = i_rst; start = i_st; stall = i_stl; halt_req = i_hr;
      branch_en = i_be; branch_rel = i_rel; taken = i_tk;
      br_idx = AW'(i_idx); target = D'(i_tg);
      @(negedge clk);
      chk("lut_addr", 32'(lut_addr), 32'(i_idx % (1 << AW)));
      chk("pc", 32'(pc), 32'(m_pc));
      chk("cycle_cnt", 32'(cycle_cnt), 32'(m_cnt));
      chk("running", 32'(running), 32'(m_st == 1));
      chk("done", 32'(done), 32'(m_st == 2));
      chk("fetch_valid", 32'(fetch_valid), 32'(m_st == 1 && !i_stl));
      @(posedge clk);
      if (i_rst) begin
         m_st = 0; m_pc = 0; m_cnt = 0;
      end else if (m_st == 0) begin
         if (i_st) begin m_st = 1; m_pc = 0; m_cnt = 0; end
      end else if (m_st == 1) begin
         m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
         if (i_stl) ;
         else if (i_hr) m_st = 2;
         else if (i_be && i_tk) m_pc = i_rel ? (m_pc + i_tg) % PMOD : i_tg % PMOD;
         else m_pc = (m_pc + 1) % PMOD;
      end else begin
         if (i_st) begin m_st = 1; m_pc = 0; m_cnt = 0; end
      end
      #1;
   endtask

   task automatic seq(input int n);
      for (int i = 0; i < n; i++)
         cyc(0, 0, 0, 0, 0, $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 15), $urandom_range(0, PMOD - 1));
   endtask

   task automatic br(input logic rel, input logic tk, input int tg);
      cyc(0, 0, 0, 0, 1, rel, tk, $urandom_range(0, 15), tg);
   endtask

   initial begin
      int pc_hold;
      int cnt_hold;
      @(posedge clk); #1;
      cyc(1, 0, 0, 0, 0, 0, 0, 3, 0);
      cyc(1, 1, 0, 1, 1, 1, 1, 5, 7);
      chk("rst_pc", 32'(pc), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_running", 32'(running), 0);
      // Idle ignores everything but start
      cyc(0, 0, 1, 1, 1, 0, 1, 9, 12'h055);
      chk("idle_pc", 32'(pc), 0);
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
      seq(4);
      chk("seq_pc4", 32'(pc), 4);
      chk("seq_cnt4", 32'(cycle_cnt), 4);
      br(1, 1, 12'hFFF);
      chk("rel_m1", 32'(pc), 3);
      br(0, 1, 20);
      br(1, 1, 12'hFFB);
      chk("rel_m5", 32'(pc), 15);
      br(0, 1, 7);
      br(0, 1, 12'h123);
      chk("abs_123", 32'(pc), 12'h123);
      br(0, 1, 7);
      br(0, 0, 12'h123);
      chk("not_taken", 32'(pc), 8);
      br(0, 1, 12'hFF0);
      br(1, 1, 12'h014);
      chk("rel_wrap", 32'(pc), 4);
      br(0, 1, 12'hFFF);
      seq(1);
      chk("seq_wrap", 32'(pc), 0);
      chk("wrap_running", 32'(running), 1);
      // Stall overrides halt and taken branch
      br(0, 1, 12'h0A5);
      pc_hold = m_pc; cnt_hold = m_cnt;
      for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1, 1, 0, 1, i, 12'h3C3);
      chk("stall_pc", 32'(pc), 32'(pc_hold));
      chk("stall_cnt", 32'(cycle_cnt), 32'(cnt_hold + 3));
      chk("stall_running", 32'(running), 1);
      cyc(0, 0, 0, 1, 1, 0, 1, 2, 12'h3C3);
      chk("halt_done", 32'(done), 1);
      chk("halt_pc", 32'(pc), 32'(pc_hold));
      for (int i = 0; i < 4; i++) cyc(0, 0, $urandom_range(0, 1), 1, 1, 1, 1, i, 12'h111);
      chk("halt_stable", 32'(pc), 32'(pc_hold));
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
      chk("restart_pc", 32'(pc), 0);
      chk("restart_done", 32'(done), 0);
      chk("restart_cnt", 32'(cycle_cnt), 0);
      seq(5);
      cyc(1, 0, 0, 0, 1, 0, 1, 4, 12'h777);
      chk("midrst_pc", 32'(pc), 0);
      chk("midrst_running", 32'(running), 0);
      chk("midrst_cnt", 32'(cycle_cnt), 0);
      // Counter saturation and freeze in halt
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
      seq(CMAX + 40);
      chk("cnt_sat", 32'(cycle_cnt), CMAX);
      cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
      seq(3);
      chk("cnt_frozen", 32'(cycle_cnt), CMAX);
      // Randomized traffic
      for (int i = 0; i < 1500; i++)
         cyc($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 19) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, PMOD - 1));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
